// File: rtl/wishbone_dev_router_if.sv
// rtl/wishbone_dev_router_if.sv - Wishbone B4 Classic controller-side bus bundle for wishbone_dev_router
interface wishbone_dev_router_if #(
    parameter int DAT_WIDTH = 32,
    parameter int ADR_WIDTH = 8
);
    logic                   cyc_i;
    logic                   stb_i;
    logic                   we_i;
    logic [ADR_WIDTH-1:0]   adr_i;
    logic [DAT_WIDTH-1:0]   dat_i;
    logic [DAT_WIDTH/8-1:0] sel_i;
    logic [DAT_WIDTH-1:0]   dat_o;
    logic                   ack_o;
    logic                   err_o;

    modport slave (
        input  cyc_i, stb_i, we_i, adr_i, dat_i, sel_i,
        output dat_o, ack_o, err_o
    );

    modport master (
        output cyc_i, stb_i, we_i, adr_i, dat_i, sel_i,
        input  dat_o, ack_o, err_o
    );
endinterface

// File: rtl/wishbone_dev_router.sv
// rtl/wishbone_dev_router.sv - Wishbone Classic device front-end routing single cycles to NUM_CH back-end devices
// Optional device timeout enabled by defining WB_DEV_ROUTER_TIMEOUT_EN.
module wishbone_dev_router #(
    parameter int                DAT_WIDTH  = 32,
    parameter int                ADR_WIDTH  = 8,
    parameter int                NUM_CH     = 4,
    parameter logic [NUM_CH-1:0] CH_PRESENT = {NUM_CH{1'b1}},
    parameter int                TIMEOUT    = 15
) (
    input  logic                                  clk_i,
    input  logic                                  rst_ni,
    wishbone_dev_router_if.slave                  wb,
    output logic [NUM_CH-1:0]                     req_o,
    output logic                                  write_en_o,
    output logic [ADR_WIDTH-$clog2(NUM_CH)-1:0]   addr_o,
    output logic [DAT_WIDTH-1:0]                  write_data_o,
    output logic [DAT_WIDTH/8-1:0]                byte_en_o,
    input  logic [NUM_CH*DAT_WIDTH-1:0]           read_data_i,
    input  logic [NUM_CH-1:0]                     ack_i
);
    localparam int CH_BITS = $clog2(NUM_CH);
    localparam int LOW_W   = ADR_WIDTH - CH_BITS;
    localparam int BE_W    = DAT_WIDTH / 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic [NUM_CH-1:0]    req_q, req_d;
    logic                 we_q, we_d;
    logic [LOW_W-1:0]     addr_q, addr_d;
    logic [DAT_WIDTH-1:0] wdata_q, wdata_d;
    logic [BE_W-1:0]      be_q, be_d;
    logic [CH_BITS-1:0]   ch_q, ch_d;
    logic [DAT_WIDTH-1:0] dat_q, dat_d;
    logic                 ack_q, ack_d;
    logic                 err_q, err_d;

    logic [CH_BITS-1:0]   adr_ch;
    logic [DAT_WIDTH-1:0] rd_sel;
    logic                 dev_ack;

`ifdef WB_DEV_ROUTER_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT + 1);
    logic [CNT_W-1:0] cnt_q, cnt_d;
`endif

    assign adr_ch  = wb.adr_i[ADR_WIDTH-1 -: CH_BITS];
    assign dev_ack = ack_i[ch_q];

    // Read data mux keyed by the latched channel, not the live address.
    always_comb begin
        rd_sel = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            if (ch_q == k[CH_BITS-1:0]) begin
                rd_sel = read_data_i[k*DAT_WIDTH +: DAT_WIDTH];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        req_d   = req_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        be_d    = be_q;
        ch_d    = ch_q;
        dat_d   = dat_q;
        ack_d   = 1'b0;
        err_d   = 1'b0;
`ifdef WB_DEV_ROUTER_TIMEOUT_EN
        cnt_d   = cnt_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (wb.cyc_i && wb.stb_i) begin
                    we_d    = wb.we_i;
                    addr_d  = wb.adr_i[LOW_W-1:0];
                    wdata_d = wb.dat_i;
                    be_d    = wb.sel_i;
                    ch_d    = adr_ch;
                    if (!CH_PRESENT[adr_ch]) begin
                        err_d   = 1'b1;
                        state_d = RESP;
                    end else begin
                        req_d         = '0;
                        req_d[adr_ch] = 1'b1;
                        state_d       = BUSY;
`ifdef WB_DEV_ROUTER_TIMEOUT_EN
                        cnt_d         = '0;
`endif
                    end
                end
            end
            BUSY: begin
                // A controller abort takes priority over a coincident device ack.
                if (!wb.cyc_i) begin
                    req_d   = '0;
                    state_d = IDLE;
                end else if (dev_ack) begin
                    if (!we_q) begin
                        dat_d = rd_sel;
                    end
                    req_d   = '0;
                    ack_d   = 1'b1;
                    state_d = RESP;
                end
`ifdef WB_DEV_ROUTER_TIMEOUT_EN
                else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                    req_d   = '0;
                    err_d   = 1'b1;
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
`endif
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                req_d   = '0;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            req_q   <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            be_q    <= '0;
            ch_q    <= '0;
            dat_q   <= '0;
            ack_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            req_q   <= req_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            be_q    <= be_d;
            ch_q    <= ch_d;
            dat_q   <= dat_d;
            ack_q   <= ack_d;
            err_q   <= err_d;
        end
    end

`ifdef WB_DEV_ROUTER_TIMEOUT_EN
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
`endif

    assign req_o        = req_q;
    assign write_en_o   = we_q;
    assign addr_o       = addr_q;
    assign write_data_o = wdata_q;
    assign byte_en_o    = be_q;
    assign wb.dat_o     = dat_q;
    assign wb.ack_o     = ack_q;
    assign wb.err_o     = err_q;
endmodule

// File: tb/tb_wishbone_dev_router.sv
// tb/tb_wishbone_dev_router.sv - directed scoreboard bench for wishbone_dev_router
module tb_wishbone_dev_router;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    wishbone_dev_router_if #(.DAT_WIDTH(32), .ADR_WIDTH(8)) wb_a ();
    wishbone_dev_router_if #(.DAT_WIDTH(32), .ADR_WIDTH(8)) wb_b ();

    logic [3:0]   req_a, req_b;
    logic         we_a, we_b;
    logic [5:0]   addr_a, addr_b;
    logic [31:0]  wdata_a, wdata_b;
    logic [3:0]   be_a, be_b;
    logic [127:0] rdata_a = '0;
    logic [127:0] rdata_b = '0;
    logic [3:0]   ack_in_a = '0;
    logic [3:0]   ack_in_b = '0;

    wishbone_dev_router #(.DAT_WIDTH(32), .ADR_WIDTH(8), .NUM_CH(4), .CH_PRESENT(4'b1111), .TIMEOUT(15)) dut (
        .clk_i(clk), .rst_ni(rst_n), .wb(wb_a.slave),
        .req_o(req_a), .write_en_o(we_a), .addr_o(addr_a), .write_data_o(wdata_a),
        .byte_en_o(be_a), .read_data_i(rdata_a), .ack_i(ack_in_a)
    );

    wishbone_dev_router #(.DAT_WIDTH(32), .ADR_WIDTH(8), .NUM_CH(4), .CH_PRESENT(4'b0111), .TIMEOUT(15)) dut_u (
        .clk_i(clk), .rst_ni(rst_n), .wb(wb_b.slave),
        .req_o(req_b), .write_en_o(we_b), .addr_o(addr_b), .write_data_o(wdata_b),
        .byte_en_o(be_b), .read_data_i(rdata_b), .ack_i(ack_in_b)
    );

    typedef struct packed {
        logic        is_err;
        logic [31:0] data;
    } exp_t;

    exp_t sb_q[$];
    int   checks = 0;
    int   failures = 0;
    int   ack_cnt_a = 0, err_cnt_a = 0, ack_cnt_b = 0, err_cnt_b = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Response monitor: pops the scoreboard on every ack/err pulse of the main instance.
    always @(negedge clk) begin
        if (rst_n) begin
            if (wb_a.ack_o) ack_cnt_a++;
            if (wb_a.err_o) err_cnt_a++;
            if (wb_b.ack_o) ack_cnt_b++;
            if (wb_b.err_o) err_cnt_b++;
            if (!$onehot0(req_a)) chk("req_onehot", req_a, 4'b0001);
            if (wb_a.ack_o && wb_a.err_o) chk("ack_err_both", 1, 0);
            if (wb_a.ack_o || wb_a.err_o) begin
                if (sb_q.size() == 0) begin
                    chk("sb_unexpected_resp", 1, 0);
                end else begin
                    exp_t e;
                    e = sb_q.pop_front();
                    chk("sb_kind", {wb_a.ack_o, wb_a.err_o}, e.is_err ? 2'b01 : 2'b10);
                    chk("sb_dat", wb_a.dat_o, e.data);
                end
            end
        end
    end

    initial begin
        wb_a.cyc_i = 0; wb_a.stb_i = 0; wb_a.we_i = 0; wb_a.adr_i = 0; wb_a.dat_i = 0; wb_a.sel_i = 0;
        wb_b.cyc_i = 0; wb_b.stb_i = 0; wb_b.we_i = 0; wb_b.adr_i = 0; wb_b.dat_i = 0; wb_b.sel_i = 0;
        #12;
        chk("reset_outputs", {req_a, we_a, addr_a, wdata_a, be_a}, '0);
        chk("reset_wb", {wb_a.dat_o, wb_a.ack_o, wb_a.err_o}, '0);
        @(negedge clk);
        rst_n = 1'b1;

        // Zero-wait read of channel 2
        rdata_a[64 +: 32] = 32'hDEADBEEF;
        ack_in_a = 4'hF;
        wb_a.adr_i = 8'h85; wb_a.we_i = 0; wb_a.cyc_i = 1; wb_a.stb_i = 1;
        sb_q.push_back('{is_err: 1'b0, data: 32'hDEADBEEF});
        tick();
        chk("zw_req", req_a, 4'b0100);
        chk("zw_addr", addr_a, 6'h05);
        chk("zw_ack_early", wb_a.ack_o, 0);
        tick();
        chk("zw_ack", wb_a.ack_o, 1);
        chk("zw_req_drop", req_a, 4'b0000);
        wb_a.cyc_i = 0; wb_a.stb_i = 0;
        tick();
        chk("zw_ack_one_cycle", wb_a.ack_o, 0);
        chk("zw_dat", wb_a.dat_o, 32'hDEADBEEF);

        // Stalled write to channel 0, four wait cycles
        ack_in_a = 4'h0;
        wb_a.adr_i = 8'h03; wb_a.dat_i = 32'h12345678; wb_a.sel_i = 4'b0011; wb_a.we_i = 1;
        wb_a.cyc_i = 1; wb_a.stb_i = 1;
        sb_q.push_back('{is_err: 1'b0, data: 32'hDEADBEEF});
        tick();
        wb_a.dat_i = 32'hFFFF_FFFF; wb_a.sel_i = 4'hF; wb_a.we_i = 0;
        for (int i = 0; i < 4; i++) begin
            chk("sw_stable", {req_a, we_a, addr_a, wdata_a, be_a}, {4'b0001, 1'b1, 6'h03, 32'h12345678, 4'b0011});
            chk("sw_no_ack", wb_a.ack_o, 0);
            tick();
        end
        ack_in_a[0] = 1'b1;
        tick();
        chk("sw_ack", wb_a.ack_o, 1);
        wb_a.cyc_i = 0; wb_a.stb_i = 0; ack_in_a = 4'h0;
        tick();
        chk("sw_ack_one_cycle", wb_a.ack_o, 0);
        chk("sw_dat_unchanged", wb_a.dat_o, 32'hDEADBEEF);
        chk("sw_ack_total", ack_cnt_a, 2);

        // Unmapped channel 3 on the second instance
        wb_b.adr_i = 8'hC0; wb_b.cyc_i = 1; wb_b.stb_i = 1;
        tick();
        chk("um_err", {wb_b.err_o, wb_b.ack_o, req_b}, {1'b1, 1'b0, 4'b0000});
        wb_b.cyc_i = 0; wb_b.stb_i = 0;
        tick();
        chk("um_err_one_cycle", {wb_b.err_o, wb_b.ack_o, req_b}, '0);
        tick();
        chk("um_counts", {ack_cnt_b[7:0], err_cnt_b[7:0]}, {8'd0, 8'd1});

        // Channel 1 never acks
        rdata_a[32 +: 32] = 32'hCAFEF00D;
        wb_a.adr_i = 8'h40; wb_a.we_i = 0; wb_a.cyc_i = 1; wb_a.stb_i = 1;
`ifdef WB_DEV_ROUTER_TIMEOUT_EN
        sb_q.push_back('{is_err: 1'b1, data: 32'hDEADBEEF});
        tick();
        for (int i = 1; i < 15; i++) begin
            chk("to_wait", {wb_a.err_o, req_a}, {1'b0, 4'b0010});
            tick();
        end
        chk("to_wait_last", {wb_a.err_o, req_a}, {1'b0, 4'b0010});
        tick();
        chk("to_err", {wb_a.err_o, wb_a.ack_o, req_a}, {1'b1, 1'b0, 4'b0000});
        wb_a.cyc_i = 0; wb_a.stb_i = 0;
        tick();
        chk("to_err_one_cycle", wb_a.err_o, 0);
`else
        tick();
        for (int i = 0; i < 20; i++) tick();
        chk("nto_still_busy", {wb_a.err_o, wb_a.ack_o, req_a}, {1'b0, 1'b0, 4'b0010});
        wb_a.cyc_i = 0; wb_a.stb_i = 0;
        tick();
        chk("nto_abort", {wb_a.err_o, wb_a.ack_o, req_a}, '0);
`endif
        tick();

        // Channel 1 acks on the fifteenth BUSY cycle
        wb_a.adr_i = 8'h41; wb_a.cyc_i = 1; wb_a.stb_i = 1;
        sb_q.push_back('{is_err: 1'b0, data: 32'hCAFEF00D});
        tick();
        for (int i = 1; i < 15; i++) tick();
        ack_in_a[1] = 1'b1;
        tick();
        chk("ack15", {wb_a.ack_o, wb_a.err_o}, 2'b10);
        wb_a.cyc_i = 0; wb_a.stb_i = 0; ack_in_a = 4'h0;
        tick();
        chk("ack15_dat", wb_a.dat_o, 32'hCAFEF00D);

        // Controller abort on BUSY cycle 2
        wb_a.adr_i = 8'h42; wb_a.cyc_i = 1; wb_a.stb_i = 1;
        tick();
        tick();
        wb_a.cyc_i = 0; wb_a.stb_i = 0;
        tick();
        chk("abort", {req_a, wb_a.ack_o, wb_a.err_o}, '0);
        tick();
        chk("abort_dat", wb_a.dat_o, 32'hCAFEF00D);

        // Asynchronous reset in the middle of BUSY
        wb_a.adr_i = 8'h40; wb_a.we_i = 1; wb_a.dat_i = 32'h0BADF00D; wb_a.sel_i = 4'hF;
        wb_a.cyc_i = 1; wb_a.stb_i = 1;
        tick();
        chk("rst_pre_req", req_a, 4'b0010);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_async", {req_a, we_a, addr_a, wdata_a, be_a, wb_a.dat_o, wb_a.ack_o, wb_a.err_o}, '0);
        wb_a.cyc_i = 0; wb_a.stb_i = 0; wb_a.we_i = 0;
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // Back-to-back reads with a sticky ack on channel 3
        rdata_a[96 +: 32] = 32'hA5A50001;
        ack_in_a = 4'b1000;
        wb_a.adr_i = 8'hC4; wb_a.cyc_i = 1; wb_a.stb_i = 1;
        sb_q.push_back('{is_err: 1'b0, data: 32'hA5A50001});
        tick();
        chk("bb_req1", req_a, 4'b1000);
        tick();
        chk("bb_ack1", wb_a.ack_o, 1);
        rdata_a[96 +: 32] = 32'h5A5A0002;
        wb_a.adr_i = 8'hC8;
        sb_q.push_back('{is_err: 1'b0, data: 32'h5A5A0002});
        tick();
        chk("bb_resp_gap", {wb_a.ack_o, req_a}, '0);
        tick();
        chk("bb_req2", {wb_a.ack_o, req_a, addr_a}, {1'b0, 4'b1000, 6'h08});
        tick();
        chk("bb_ack2", wb_a.ack_o, 1);
        wb_a.cyc_i = 0; wb_a.stb_i = 0;
        tick();
        tick();
        chk("bb_dat2", wb_a.dat_o, 32'h5A5A0002);
        ack_in_a = 4'h0;

        tick();
        chk("total_acks", ack_cnt_a, 5);
`ifdef WB_DEV_ROUTER_TIMEOUT_EN
        chk("total_errs", err_cnt_a, 1);
`else
        chk("total_errs", err_cnt_a, 0);
`endif
        chk("sb_empty", sb_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
